// File: rtl/fmul_pkg.sv
// Shared types and constants for the iterative floating-point multiplier.
package fmul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } cls_e;

   function automatic int unsigned exp_bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 1)) - 32'd1;
   endfunction

   function automatic int unsigned exp_ones(input int unsigned exp_w);
      return (32'd1 << exp_w) - 32'd1;
   endfunction

   // Subnormals (exponent 0) are treated as zero.
   function automatic cls_e classify(input logic exp_zero, input logic exp_all_ones,
                                     input logic man_zero);
      if (exp_zero)          return CLS_ZERO;
      else if (!exp_all_ones) return CLS_NORM;
      else if (man_zero)     return CLS_INF;
      else                   return CLS_NAN;
   endfunction

endpackage

// File: rtl/fmul_if.sv
// Operand/result handshake bundle for fmul_iterative.
interface fmul_if #(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
);
   logic             in_Valid;
   logic             in_Ready;
   logic             in_Sign_1;
   logic             in_Sign_2;
   logic [EXP_W-1:0] in_Exponent_1;
   logic [EXP_W-1:0] in_Exponent_2;
   logic [MAN_W-1:0] in_Mantissa_1;
   logic [MAN_W-1:0] in_Mantissa_2;
   logic             out_Valid;
   logic             out_Ready;
   logic             out_Sign;
   logic [EXP_W-1:0] out_Exponent;
   logic [MAN_W-1:0] out_Mantissa;
   logic             SC_Exponent_Overflow;
   logic             SC_Exponent_Underflow;
   logic             SC_Invalid;

   modport master (
      output in_Valid, in_Sign_1, in_Sign_2, in_Exponent_1, in_Exponent_2,
             in_Mantissa_1, in_Mantissa_2, out_Ready,
      input  in_Ready, out_Valid, out_Sign, out_Exponent, out_Mantissa,
             SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid
   );

   modport slave (
      input  in_Valid, in_Sign_1, in_Sign_2, in_Exponent_1, in_Exponent_2,
             in_Mantissa_1, in_Mantissa_2, out_Ready,
      output in_Ready, out_Valid, out_Sign, out_Exponent, out_Mantissa,
             SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid
   );
endinterface

// File: rtl/fmul_round_norm.sv
// Normalises the raw significand product, rounds to nearest-even and detects range errors.
module fmul_round_norm
   import fmul_pkg::*;
#(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
) (
   input  logic [2*(MAN_W+1)-1:0] prod_i,
   input  logic signed [EXP_W+1:0] exp_i,
   output logic [EXP_W-1:0]       exp_c_o,
   output logic [MAN_W-1:0]       man_c_o,
   output logic                   ovf_c_o,
   output logic                   unf_c_o
);
   localparam int unsigned PRD_W = 2 * (MAN_W + 1);
   localparam int unsigned FRC_W = PRD_W - 1;
   localparam int unsigned EXS_W = EXP_W + 2;
   localparam int unsigned MRW   = MAN_W + 1;
   localparam logic signed [EXS_W-1:0] EXP_MAX  = EXS_W'(exp_ones(EXP_W));
   localparam logic [EXP_W-1:0]        EXP_ONES = EXP_W'(exp_ones(EXP_W));

   logic                    msb;
   logic [FRC_W-1:0]        frac;
   logic [MAN_W-1:0]        man_t;
   logic                    guard;
   logic                    sticky;
   logic                    rnd_up;
   logic [MAN_W:0]          man_r;
   logic signed [EXS_W-1:0] exp_f;

   always_comb begin
      msb     = prod_i[PRD_W-1];
      // Fraction bits below the leading one, left-aligned.
      frac    = msb ? prod_i[PRD_W-2:0] : {prod_i[PRD_W-3:0], 1'b0};
      man_t   = frac[FRC_W-1 -: MAN_W];
      guard   = frac[MAN_W];
      sticky  = |frac[MAN_W-1:0];
      rnd_up  = guard & (sticky | man_t[0]);
      man_r   = {1'b0, man_t} + MRW'(rnd_up);
      exp_f   = exp_i + EXS_W'(msb) + EXS_W'(man_r[MAN_W]);
      exp_c_o = exp_f[EXP_W-1:0];
      man_c_o = man_r[MAN_W-1:0];
      ovf_c_o = 1'b0;
      unf_c_o = 1'b0;
      if (exp_f >= EXP_MAX) begin
         ovf_c_o = 1'b1;
         exp_c_o = EXP_ONES;
         man_c_o = '0;
      end else if (exp_f[EXS_W-1] || (exp_f == '0)) begin
         unf_c_o = 1'b1;
         exp_c_o = '0;
         man_c_o = '0;
      end
   end
endmodule

// File: rtl/fmul_iterative.sv
// Iterative shift-add floating-point multiplier with valid/ready handshakes.
module fmul_iterative
   import fmul_pkg::*;
#(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
) (
   input logic  clk,
   input logic  rst_n,
   fmul_if.slave bus
);
   localparam int unsigned SIG_W = MAN_W + 1;
   localparam int unsigned PRD_W = 2 * SIG_W;
   localparam int unsigned EXS_W = EXP_W + 2;
   localparam int unsigned CNT_W = $clog2(SIG_W + 1);
   localparam logic [EXP_W-1:0]        EXP_ONES = EXP_W'(exp_ones(EXP_W));
   localparam logic signed [EXS_W-1:0] BIAS     = EXS_W'(exp_bias(EXP_W));
   localparam logic [MAN_W-1:0]        QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};

   state_e                  state_q, state_d;
   logic                    sign_q, sign_d;
   logic [EXP_W-1:0]        e1_q, e1_d, e2_q, e2_d;
   logic [MAN_W-1:0]        m1_q, m1_d, m2_q, m2_d;
   logic [PRD_W-1:0]        mand_q, mand_d;
   logic [SIG_W-1:0]        mplr_q, mplr_d;
   logic [PRD_W-1:0]        acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [EXS_W-1:0] exp_q, exp_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    res_sign_q, res_sign_d;
   logic [EXP_W-1:0]        res_exp_q, res_exp_d;
   logic [MAN_W-1:0]        res_man_q, res_man_d;
   logic                    ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

   cls_e                    cls1, cls2;
   logic                    any_nan, any_inf, any_zero;
   logic [EXP_W-1:0]        rn_exp;
   logic [MAN_W-1:0]        rn_man;
   logic                    rn_ovf, rn_unf;

   fmul_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_norm (
      .prod_i  (acc_q),
      .exp_i   (exp_q),
      .exp_c_o (rn_exp),
      .man_c_o (rn_man),
      .ovf_c_o (rn_ovf),
      .unf_c_o (rn_unf)
   );

   always_comb begin
      cls1     = classify(bus.in_Exponent_1 == '0, bus.in_Exponent_1 == EXP_ONES,
                          bus.in_Mantissa_1 == '0);
      cls2     = classify(bus.in_Exponent_2 == '0, bus.in_Exponent_2 == EXP_ONES,
                          bus.in_Mantissa_2 == '0);
      any_nan  = (cls1 == CLS_NAN)  || (cls2 == CLS_NAN);
      any_inf  = (cls1 == CLS_INF)  || (cls2 == CLS_INF);
      any_zero = (cls1 == CLS_ZERO) || (cls2 == CLS_ZERO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sign_q      <= 1'b0;
         e1_q        <= '0;
         e2_q        <= '0;
         m1_q        <= '0;
         m2_q        <= '0;
         mand_q      <= '0;
         mplr_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         exp_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_sign_q  <= 1'b0;
         res_exp_q   <= '0;
         res_man_q   <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         inv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         e1_q        <= e1_d;
         e2_q        <= e2_d;
         m1_q        <= m1_d;
         m2_q        <= m2_d;
         mand_q      <= mand_d;
         mplr_q      <= mplr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         exp_q       <= exp_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         res_sign_q  <= res_sign_d;
         res_exp_q   <= res_exp_d;
         res_man_q   <= res_man_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         inv_q       <= inv_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      e1_d       = e1_q;
      e2_d       = e2_q;
      m1_d       = m1_q;
      m2_d       = m2_q;
      mand_d     = mand_q;
      mplr_d     = mplr_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      res_sign_d = res_sign_q;
      res_exp_d  = res_exp_q;
      res_man_d  = res_man_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      inv_d      = inv_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_Valid) begin
               sign_d = bus.in_Sign_1 ^ bus.in_Sign_2;
               e1_d   = bus.in_Exponent_1;
               e2_d   = bus.in_Exponent_2;
               m1_d   = bus.in_Mantissa_1;
               m2_d   = bus.in_Mantissa_2;
               cnt_d  = '0;
               acc_d  = '0;
               if (!any_nan && !any_inf && !any_zero) begin
                  state_d = S_MUL;
               end else begin
                  // Special operands bypass the datapath entirely.
                  state_d    = S_DONE;
                  ovf_d      = 1'b0;
                  unf_d      = 1'b0;
                  inv_d      = 1'b0;
                  res_sign_d = bus.in_Sign_1 ^ bus.in_Sign_2;
                  res_exp_d  = '0;
                  res_man_d  = '0;
                  if (any_nan || (any_inf && any_zero)) begin
                     res_sign_d = 1'b0;
                     res_exp_d  = EXP_ONES;
                     res_man_d  = QNAN_MAN;
                     inv_d      = !any_nan;
                  end else if (any_inf) begin
                     res_exp_d  = EXP_ONES;
                  end
               end
            end
         end
         S_MUL: begin
            // Count 0 builds the significands and exponent sum; counts 1..SIG_W add one partial product each.
            if (cnt_q == '0) begin
               mand_d = PRD_W'({1'b1, m1_q});
               mplr_d = {1'b1, m2_q};
               acc_d  = '0;
               exp_d  = $signed({2'b00, e1_q}) + $signed({2'b00, e2_q}) - BIAS;
            end else begin
               if (mplr_q[0]) acc_d = acc_q + mand_q;
               mand_d = mand_q << 1;
               mplr_d = mplr_q >> 1;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SIG_W)) state_d = S_NORM;
         end
         S_NORM: begin
            state_d    = S_DONE;
            res_sign_d = rn_ovf || !rn_unf ? sign_q : sign_q;
            res_exp_d  = rn_exp;
            res_man_d  = rn_man;
            ovf_d      = rn_ovf;
            unf_d      = rn_unf;
            inv_d      = 1'b0;
         end
         S_DONE: begin
            if (bus.out_Ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   assign bus.in_Ready              = in_ready_q;
   assign bus.out_Valid             = out_valid_q;
   assign bus.out_Sign              = res_sign_q;
   assign bus.out_Exponent          = res_exp_q;
   assign bus.out_Mantissa          = res_man_q;
   assign bus.SC_Exponent_Overflow  = ovf_q;
   assign bus.SC_Exponent_Underflow = unf_q;
   assign bus.SC_Invalid            = inv_q;
endmodule

// File: tb/tb_fmul_iterative.sv
// Self-checking bench for fmul_iterative at half precision (EXP_W=5, MAN_W=10).
module tb_fmul_iterative;

   typedef struct packed {
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      logic        inv;
      logic [7:0]  lat;
   } ref_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      ref_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   fmul_if #(.EXP_W(5), .MAN_W(10)) bus ();

   fmul_iterative #(.EXP_W(5), .MAN_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Reference: exact integer product of significands, rounded to nearest-even.
   function automatic ref_t model(input logic [15:0] a, input logic [15:0] b);
      ref_t r;
      int ea, eb, ma, mb, p, sh, q, rem, half, e;
      bit s, za, zb, ia, ib, na, nb;
      r  = '0;
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      ma = int'(a[9:0]);   mb = int'(b[9:0]);
      s  = a[15] ^ b[15];
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == 31) && (ma == 0); ib = (eb == 31) && (mb == 0);
      na = (ea == 31) && (ma != 0); nb = (eb == 31) && (mb != 0);
      r.lat = 8'd1;
      if (na || nb) r.res = 16'h7E00;
      else if ((ia && zb) || (za && ib)) begin r.res = 16'h7E00; r.inv = 1'b1; end
      else if (ia || ib) r.res = {s, 15'h7C00};
      else if (za || zb) r.res = {s, 15'h0000};
      else begin
         r.lat = 8'd14;
         p    = (1024 + ma) * (1024 + mb);
         sh   = (p >= (1 << 21)) ? 11 : 10;
         e    = ea + eb - 15 + sh - 10;
         q    = p >> sh;
         rem  = p - (q << sh);
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && (q % 2) == 1)) q++;
         if (q == 2048) begin q = 1024; e++; end
         if (e >= 31) begin r.res = {s, 15'h7C00}; r.ovf = 1'b1; end
         else if (e <= 0) begin r.res = {s, 15'h0000}; r.unf = 1'b1; end
         else r.res = {s, 5'(e), 10'(q - 1024)};
      end
      return r;
   endfunction

   function automatic logic [15:0] rand_op();
      int sel;
      logic [4:0] e;
      logic [9:0] m;
      sel = int'($urandom_range(0, 11));
      m   = 10'($urandom);
      if (sel == 0) e = 5'd0;
      else if (sel == 1) begin e = 5'd31; if ($urandom_range(0, 1) == 0) m = '0; end
      else e = 5'($urandom_range(1, 30));
      return {1'($urandom), e, m};
   endfunction

   function automatic logic [15:0] out_word();
      return {bus.out_Sign, bus.out_Exponent, bus.out_Mantissa};
   endfunction

   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.in_Ready && w < 100) begin @(negedge clk); w++; end
      chk("in_ready_before_send", 32'(bus.in_Ready), 32'd1);
      bus.in_Valid      = 1'b1;
      bus.in_Sign_1     = a[15]; bus.in_Exponent_1 = a[14:10]; bus.in_Mantissa_1 = a[9:0];
      bus.in_Sign_2     = b[15]; bus.in_Exponent_2 = b[14:10]; bus.in_Mantissa_2 = b[9:0];
      @(posedge clk);
      #1;
      bus.in_Valid      = 1'b0;
      {bus.in_Sign_1, bus.in_Exponent_1, bus.in_Mantissa_1} = 16'($urandom);
      {bus.in_Sign_2, bus.in_Exponent_2, bus.in_Mantissa_2} = 16'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_Valid && lat < 100);
   endtask

   task automatic take(input string nm);
      bus.out_Ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_Ready = 1'b0;
      @(negedge clk);
      chk({nm, "_idle_after_xfer"}, {30'd0, bus.in_Ready, bus.out_Valid}, 32'b10);
   endtask

   task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input ref_t req);
      int lat;
      send(a, b);
      wait_out(lat);
      chk({nm, "_latency"}, 32'(lat), 32'(req.lat));
      chk({nm, "_result"}, 32'(out_word()), 32'(req.res));
      chk({nm, "_flags"},
          {29'd0, bus.SC_Exponent_Overflow, bus.SC_Exponent_Underflow, bus.SC_Invalid},
          {29'd0, req.ovf, req.unf, req.inv});
      take(nm);
   endtask

   initial begin
      vec_t vecs[$];
      logic [15:0] held;
      logic [15:0] a, b;
      int lat;
      bit leak;

      vecs.push_back('{16'h3C00, 16'h3E00, '{16'h3E00, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h4000, 16'hC200, '{16'hC600, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h3C01, 16'h3C01, '{16'h3C02, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h7BFF, 16'h4000, '{16'h7C00, 1'b1, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h0400, 16'h3800, '{16'h0000, 1'b0, 1'b1, 1'b0, 8'd14}});
      vecs.push_back('{16'h7C00, 16'h0000, '{16'h7E00, 1'b0, 1'b0, 1'b1, 8'd1}});
      vecs.push_back('{16'h8000, 16'h3C00, '{16'h8000, 1'b0, 1'b0, 1'b0, 8'd1}});
      vecs.push_back('{16'h7E00, 16'h3C00, '{16'h7E00, 1'b0, 1'b0, 1'b0, 8'd1}});
      vecs.push_back('{16'hFC00, 16'h3C00, '{16'hFC00, 1'b0, 1'b0, 1'b0, 8'd1}});
      vecs.push_back('{16'h3C01, 16'h3E00, '{16'h3E02, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h3C03, 16'h3E00, '{16'h3E04, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h3DA8, 16'h3DA8, '{16'h4000, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h0400, 16'h3C00, '{16'h0400, 1'b0, 1'b0, 1'b0, 8'd14}});
      vecs.push_back('{16'h7BFF, 16'h3C00, '{16'h7BFF, 1'b0, 1'b0, 1'b0, 8'd14}});

      rst_n         = 1'b0;
      bus.in_Valid  = 1'b0;
      bus.out_Ready = 1'b0;
      {bus.in_Sign_1, bus.in_Exponent_1, bus.in_Mantissa_1} = '0;
      {bus.in_Sign_2, bus.in_Exponent_2, bus.in_Mantissa_2} = '0;
      repeat (3) @(negedge clk);
      chk("reset_handshake", {30'd0, bus.in_Ready, bus.out_Valid}, 32'b10);
      chk("reset_outputs", {13'd0, out_word(), bus.SC_Exponent_Overflow,
          bus.SC_Exponent_Underflow, bus.SC_Invalid}, 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

      // Backpressure: result held for 5 cycles, new requests ignored, then exactly one transfer.
      send(16'h4000, 16'hC200);
      wait_out(lat);
      chk("bp_latency", 32'(lat), 32'd14);
      held = out_word();
      chk("bp_result", 32'(held), 32'hC600);
      for (int k = 0; k < 5; k++) begin
         bus.in_Valid = 1'b1;
         {bus.in_Sign_1, bus.in_Exponent_1, bus.in_Mantissa_1} = 16'h3C00;
         {bus.in_Sign_2, bus.in_Exponent_2, bus.in_Mantissa_2} = 16'h3C00;
         @(negedge clk);
         chk($sformatf("bp_hold%0d", k), {13'd0, out_word(), bus.out_Valid, bus.in_Ready,
             bus.SC_Invalid}, {13'd0, held, 1'b1, 1'b0, 1'b0});
      end
      bus.in_Valid = 1'b0;
      take("bp");
      leak = 1'b0;
      repeat (16) begin @(negedge clk); if (bus.out_Valid) leak = 1'b1; end
      chk("bp_single_transfer", 32'(leak), 32'd0);

      // Asynchronous reset during MUL discards the operation.
      send(16'h3C01, 16'h3C01);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_handshake", {30'd0, bus.in_Ready, bus.out_Valid}, 32'b10);
      chk("midrst_outputs", {13'd0, out_word(), bus.SC_Exponent_Overflow,
          bus.SC_Exponent_Underflow, bus.SC_Invalid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      leak = 1'b0;
      repeat (20) begin @(negedge clk); if (bus.out_Valid || !bus.in_Ready) leak = 1'b1; end
      chk("midrst_no_result", 32'(leak), 32'd0);
      run_op("after_rst", 16'h3C00, 16'h3C00, '{16'h3C00, 1'b0, 1'b0, 1'b0, 8'd14});

      for (int i = 0; i < 60; i++) begin
         a = rand_op();
         b = rand_op();
         run_op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, model(a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
